// File: rtl/axis_uart_rx_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_rx_wrapper
// Purpose  : 8N1 UART receiver (LSB first, idle-high line) feeding an
//            AXI-Stream master through a first-word-fall-through FIFO.
// Ports    : clk        - system clock, rising edge
//            rst_n      - synchronous reset, active-low
//            rx         - asynchronous serial input, idle high
//            o_tdata    - byte at FIFO head (valid only when o_tvalid=1)
//            o_tvalid   - FIFO not empty
//            o_tready   - downstream accept
//            fifo_level - bytes held in the FIFO, zero-extended to 16 bits
//            frame_err  - 1-cycle pulse: stop bit sampled low, byte dropped
//            overrun    - 1-cycle pulse: byte completed while FIFO full
//            busy       - receiver FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_rx_wrapper #(
  parameter int RX_SIZE   = 4,
  parameter int clkdiv_rx = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] fifo_level,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int          c_DEPTH = 1 << RX_SIZE;
  localparam logic [15:0] c_LAST  = 16'(clkdiv_rx - 1);
  localparam logic [15:0] c_HALF  = 16'(clkdiv_rx / 2 - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
  localparam logic [2:0] c_BREAK = 3'd4;

  // --------------------------------------------------------------------------
  // Receiver state and datapath
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rx_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_push;
  logic        r_frame_err;

  logic        w_start_sample;
  logic        w_bit_sample;
  logic        w_stop_sample;
  logic        w_cnt_clr;

  assign w_rx_s = r_sync2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (!w_rx_s) w_next_state = c_START;
      end
      c_START: begin
        // A start bit that is high again at mid-bit was only a glitch
        if (r_cnt == c_HALF) w_next_state = w_rx_s ? c_IDLE : c_DATA;
      end
      c_DATA: begin
        if ((r_cnt == c_LAST) && (r_idx == 3'd7)) w_next_state = c_STOP;
      end
      c_STOP: begin
        if (r_cnt == c_LAST) w_next_state = w_rx_s ? c_IDLE : c_BREAK;
      end
      c_BREAK: begin
        // Wait out a held-low line so it reports only one frame error
        if (w_rx_s) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output / sample-strobe logic
  always_comb begin
    w_start_sample = (r_state == c_START) && (r_cnt == c_HALF);
    w_bit_sample   = (r_state == c_DATA)  && (r_cnt == c_LAST);
    w_stop_sample  = (r_state == c_STOP)  && (r_cnt == c_LAST);
    w_cnt_clr      = (r_state == c_IDLE) || (r_state == c_BREAK) ||
                     w_start_sample || w_bit_sample || w_stop_sample;
    busy           = (r_state != c_IDLE);
  end

  // Synchroniser, bit timing and shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_cnt       <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      // The push lands one cycle after the stop sample; r_shift is stable then
      r_push      <= w_stop_sample && w_rx_s;
      r_frame_err <= w_stop_sample && !w_rx_s;
      if (w_start_sample) begin
        r_idx <= 3'd0;
      end else if (w_bit_sample) begin
        r_idx <= r_idx + 3'd1;
      end
      // LSB arrives first, so shift in from the top
      if (w_bit_sample) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [c_DEPTH];
  logic [RX_SIZE-1:0] r_wr_ptr;
  logic [RX_SIZE-1:0] r_rd_ptr;
  logic [RX_SIZE:0]   r_count;
  logic               w_full;
  logic               w_push_ok;
  logic               w_pop;

  // Full is judged before any same-cycle pop, so a full FIFO rejects the push
  assign w_full    = (r_count == (RX_SIZE + 1)'(c_DEPTH));
  assign w_push_ok = r_push && !w_full;
  assign w_pop     = o_tvalid && o_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (rst_n && w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  assign o_tdata    = r_mem[r_rd_ptr];
  assign o_tvalid   = (r_count != '0);
  assign fifo_level = 16'(r_count);
  assign frame_err  = r_frame_err && rst_n;
  assign overrun    = r_push && w_full && rst_n;

endmodule
`default_nettype wire
